// File: rtl/video_cap_pkg.sv
// Shared types and widths for the video stream capture path.
package video_cap_pkg;

    localparam int PIX_W = 24;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        LINE
    } cap_state_t;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] data;
    } fifo_entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered read port; the output register counts
// towards DEPTH, so at most DEPTH entries are held in total.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      mem_cnt;
    logic [AW:0]      total;
    logic             rd_valid;
    logic             pop;
    logic             push;
    logic             load;

    assign total = mem_cnt + {{AW{1'b0}}, rd_valid};
    assign full  = (total == (AW+1)'(DEPTH));
    assign empty = ~rd_valid;
    assign pop   = rd_en & rd_valid;
    assign push  = wr_en & (~full | pop);
    // Refill the output register whenever it is free or being consumed.
    assign load  = (mem_cnt != '0) & (~rd_valid | pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) begin
                rd_data  <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
            case ({push, load})
                2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

endmodule

// File: rtl/video_stream_capture.sv
// Captures a vsync/valid framed pixel stream into a FIFO with sof/eol tags and
// measures resolution. Optional checksum build: define VSC_FRAME_SUM_EN.
module video_stream_capture
    import video_cap_pkg::*;
#(
    parameter int H_DISP     = 1280,
    parameter int V_DISP     = 720,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             vin_vsync,
    input  logic             vin_hsync,
    input  logic             vin_valid,
    input  logic [PIX_W-1:0] vin_dat,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] meas_xres,
    output logic [CNT_W-1:0] meas_yres,
    output logic             frame_done,
    output logic             frame_err,
    output logic             ovf_err,
    output logic [31:0]      frame_sum
);

    cap_state_t       state;
    logic             vsync_d;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] row_inc;
    logic             sof_pending;
    logic             skid_valid;
    logic             skid_sof;
    logic [PIX_W-1:0] skid_data;
    fifo_entry_t      fifo_in;
    fifo_entry_t      fifo_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             vs_rise;
    logic             start;
    logic             capture;
    logic             line_end;
    logic             last_line;
    logic             hsync_unused;

    // Line framing comes from vin_valid; hsync carries no timing role here.
    assign hsync_unused = vin_hsync;

    assign vs_rise   = vin_vsync & ~vsync_d;
    assign start     = vs_rise & enable;
    assign capture   = (state != IDLE) & vin_valid;
    assign line_end  = (state == LINE) & ~vin_valid;
    assign row_inc   = sat_inc(row);
    assign last_line = line_end & (row_inc == CNT_W'(V_DISP));
    assign pop       = m_valid & m_ready;

    // eol is decided when the skid entry is written: the line ended if valid dropped.
    assign fifo_in = '{sof: skid_sof, eol: ~vin_valid, data: skid_data};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (skid_valid),
        .wr_data (fifo_in),
        .rd_en   (m_ready),
        .rd_data (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_data  = fifo_out.data;
    assign m_sof   = fifo_out.sof;
    assign m_eol   = fifo_out.eol;
    assign m_valid = ~fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            vsync_d     <= 1'b0;
            col         <= '0;
            row         <= '0;
            sof_pending <= 1'b0;
            skid_valid  <= 1'b0;
            skid_sof    <= 1'b0;
            skid_data   <= '0;
            meas_xres   <= '0;
            meas_yres   <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            vsync_d    <= vin_vsync;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            skid_valid <= capture;
            if (capture) begin
                skid_data   <= vin_dat;
                skid_sof    <= sof_pending;
                sof_pending <= 1'b0;
                col         <= sat_inc(col);
            end
            if (skid_valid && fifo_full && !pop) ovf_err <= 1'b1;

            case (state)
                IDLE: ;
                default: begin
                    if (vin_valid) state <= LINE;
                    if (line_end) begin
                        state     <= WAIT_LINE;
                        row       <= row_inc;
                        col       <= '0;
                        meas_xres <= col;
                        if (col != CNT_W'(H_DISP)) frame_err <= 1'b1;
                    end
                    if (last_line) begin
                        frame_done <= 1'b1;
                        meas_yres  <= CNT_W'(V_DISP);
                        state      <= IDLE;
                    end
                    // A vsync coinciding with the final line end is a clean frame boundary.
                    if (vs_rise) begin
                        state <= IDLE;
                        if (!last_line) begin
                            frame_err <= 1'b1;
                            meas_yres <= line_end ? row_inc : row;
                        end
                    end
                end
            endcase

            if (start) begin
                state       <= WAIT_LINE;
                row         <= '0;
                col         <= '0;
                sof_pending <= 1'b1;
                ovf_err     <= 1'b0;
            end
        end
    end

`ifdef VSC_FRAME_SUM_EN
    logic [31:0] sum_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else begin
            if (last_line) frame_sum <= sum_acc;
            if (start) begin
                sum_acc <= '0;
            end else if (capture) begin
                sum_acc <= sum_acc + 32'(vin_dat);
            end
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_video_stream_capture.sv
// Directed bench for video_stream_capture with an 8x4 frame and a 16-entry FIFO.
module tb_video_stream_capture;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int DEPTH = 16;

`ifdef VSC_FRAME_SUM_EN
    localparam logic [31:0] EXP_SUM_NOM  = 32'd112;
    localparam logic [31:0] EXP_SUM_ONES = 32'h1FFF_FFE0;
`else
    localparam logic [31:0] EXP_SUM_NOM  = 32'd0;
    localparam logic [31:0] EXP_SUM_ONES = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        vin_vsync;
    logic        vin_hsync;
    logic        vin_valid;
    logic [23:0] vin_dat;
    logic [23:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] meas_xres;
    logic [15:0] meas_yres;
    logic        frame_done;
    logic        frame_err;
    logic        ovf_err;
    logic [31:0] frame_sum;

    always #5 clk = ~clk;

    video_stream_capture #(
        .H_DISP     (H),
        .V_DISP     (V),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .vin_vsync  (vin_vsync),
        .vin_hsync  (vin_hsync),
        .vin_valid  (vin_valid),
        .vin_dat    (vin_dat),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .meas_xres  (meas_xres),
        .meas_yres  (meas_yres),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .ovf_err    (ovf_err),
        .frame_sum  (frame_sum)
    );

    logic [25:0] q[$];
    int          done_cnt;
    int          err_cnt;
    int          n_vec;
    int          n_err;
    logic [15:0] err_xres;
    logic [15:0] err_yres;
    logic [31:0] done_sum;

    // Records popped entries and event pulses midway between rising edges.
    always @(negedge clk) begin
        if (m_valid && m_ready) q.push_back({m_sof, m_eol, m_data});
        if (frame_done) begin
            done_cnt++;
            done_sum = frame_sum;
        end
        if (frame_err) begin
            err_cnt++;
            err_xres = meas_xres;
            err_yres = meas_yres;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic pulse_vsync();
        vin_vsync = 1'b1;
        tick();
        vin_vsync = 1'b0;
        tick();
    endtask

    task automatic drive_line(input int npix, input bit ones, input bit vs_end, input bit lat);
        for (int i = 0; i < npix; i++) begin
            vin_valid = 1'b1;
            vin_dat   = ones ? 24'hFFFFFF : 24'(i);
            tick();
            if (lat && i < 2) check("latency_hold", 32'(m_valid), 32'd0);
            if (lat && i == 2) check("latency_first", 32'({m_valid, m_sof, m_data}), 32'({2'b11, 24'd0}));
        end
        vin_valid = 1'b0;
        vin_dat   = '0;
        vin_vsync = vs_end;
        vin_hsync = 1'b1;
        tick();
        vin_vsync = 1'b0;
        vin_hsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic drive_frame(input bit ones);
        for (int l = 0; l < V; l++) drive_line(H, ones, 1'b0, 1'b0);
    endtask

    // Entry k of a column-index frame: sof on k==0, eol on the last column.
    task automatic check_frame(input string tag, input int base, input int count);
        for (int k = 0; k < count; k++)
            check(tag, 32'(q[base + k]), 32'({k == 0, (k % H) == H - 1, 24'(k % H)}));
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        vin_vsync = 1'b0;
        vin_hsync = 1'b0;
        vin_valid = 1'b0;
        vin_dat   = '0;
        m_ready   = 1'b1;
        repeat (3) tick();

        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_tags", 32'({m_sof, m_eol, m_data}), 32'd0);
        check("rst_meas", {meas_yres, meas_xres}, 32'd0);
        check("rst_pulses", 32'({frame_done, frame_err, ovf_err}), 32'd0);
        check("rst_frame_sum", frame_sum, 32'd0);

        rst    = 1'b0;
        enable = 1'b1;
        tick();

        // Nominal frame with first-pixel latency probe.
        clear_mon();
        pulse_vsync();
        drive_line(H, 1'b0, 1'b0, 1'b1);
        for (int l = 1; l < V; l++) drive_line(H, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        check("nom_count", 32'(q.size()), 32'd32);
        check_frame("nom_pixel", 0, 32);
        check("nom_done", 32'(done_cnt), 32'd1);
        check("nom_err", 32'(err_cnt), 32'd0);
        check("nom_xres", 32'(meas_xres), 32'd8);
        check("nom_yres", 32'(meas_yres), 32'd4);
        check("nom_sum", done_sum, EXP_SUM_NOM);

        // Short second line.
        clear_mon();
        pulse_vsync();
        drive_line(8, 1'b0, 1'b0, 1'b0);
        drive_line(6, 1'b0, 1'b0, 1'b0);
        drive_line(8, 1'b0, 1'b0, 1'b0);
        drive_line(8, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        check("short_err", 32'(err_cnt), 32'd1);
        check("short_err_xres", 32'(err_xres), 32'd6);
        check("short_done", 32'(done_cnt), 32'd1);
        check("short_yres", 32'(meas_yres), 32'd4);
        check("short_xres_end", 32'(meas_xres), 32'd8);
        check("short_count", 32'(q.size()), 32'd30);
        check("short_eol", 32'(q[13]), 32'({2'b01, 24'd5}));
        check("short_next", 32'(q[14]), 32'd0);

        // Early vsync after two lines restarts the frame.
        clear_mon();
        pulse_vsync();
        drive_line(H, 1'b0, 1'b0, 1'b0);
        drive_line(H, 1'b0, 1'b0, 1'b0);
        pulse_vsync();
        drive_frame(1'b0);
        repeat (6) tick();
        check("abort_err", 32'(err_cnt), 32'd1);
        check("abort_yres", 32'(err_yres), 32'd2);
        check("abort_done", 32'(done_cnt), 32'd1);
        check("abort_count", 32'(q.size()), 32'd48);
        check_frame("abort_part", 0, 16);
        check_frame("abort_full", 16, 32);

        // Last line end and next vsync on the same edge.
        clear_mon();
        pulse_vsync();
        for (int l = 0; l < V - 1; l++) drive_line(H, 1'b0, 1'b0, 1'b0);
        drive_line(H, 1'b0, 1'b1, 1'b0);
        drive_frame(1'b0);
        repeat (6) tick();
        check("b2b_done", 32'(done_cnt), 32'd2);
        check("b2b_err", 32'(err_cnt), 32'd0);
        check("b2b_count", 32'(q.size()), 32'd64);
        check("b2b_sof2", 32'(q[32]), 32'({2'b10, 24'd0}));
        check("b2b_sum", done_sum, EXP_SUM_NOM);

        // Back-pressure for a whole frame overflows the FIFO.
        clear_mon();
        m_ready = 1'b0;
        pulse_vsync();
        drive_frame(1'b0);
        repeat (4) tick();
        check("ovf_flag", 32'(ovf_err), 32'd1);
        check("ovf_hold", 32'({m_valid, m_sof, m_eol, m_data}), 32'({3'b110, 24'd0}));
        check("ovf_done", 32'(done_cnt), 32'd1);
        m_ready = 1'b1;
        repeat (20) tick();
        check("ovf_count", 32'(q.size()), 32'd16);
        check_frame("ovf_pixel", 0, 16);
        check("ovf_sticky", 32'(ovf_err), 32'd1);

        // Reset in the middle of line 3.
        clear_mon();
        pulse_vsync();
        check("ovf_cleared", 32'(ovf_err), 32'd0);
        drive_line(H, 1'b0, 1'b0, 1'b0);
        drive_line(H, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vin_valid = 1'b1;
            vin_dat   = 24'(i);
            tick();
        end
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'({m_valid, m_sof, m_eol}), 32'd0);
        check("mid_rst_data", 32'(m_data), 32'd0);
        check("mid_rst_meas", {meas_yres, meas_xres}, 32'd0);
        check("mid_rst_flags", 32'({frame_done, frame_err, ovf_err}), 32'd0);
        check("mid_rst_sum", frame_sum, 32'd0);
        vin_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        clear_mon();
        drive_line(H, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        pulse_vsync();
        drive_line(H, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("idle_ignored", 32'(q.size()), 32'd0);
        enable = 1'b1;
        pulse_vsync();
        drive_frame(1'b0);
        repeat (6) tick();
        check("post_rst_count", 32'(q.size()), 32'd32);
        check_frame("post_rst_pixel", 0, 32);
        check("post_rst_done", 32'(done_cnt), 32'd1);
        check("post_rst_meas", {meas_yres, meas_xres}, {16'd4, 16'd8});

        // All-ones pixels for the checksum.
        clear_mon();
        pulse_vsync();
        drive_frame(1'b1);
        repeat (6) tick();
        check("ones_done", 32'(done_cnt), 32'd1);
        check("ones_sum_at_done", done_sum, EXP_SUM_ONES);
        check("ones_sum_held", frame_sum, EXP_SUM_ONES);
        check("ones_pixel", 32'(q[5]), 32'({2'b00, 24'hFFFFFF}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
